// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// 64-bit ops complete in 66 cycles after accept and W-forms in 34 cycles.
// A divide by zero or a signed overflow completes in one cycle.
module mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [1:0]      op_i,
    input  logic            unsign_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MIN64 = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN32 = {{(XLEN-31){1'b1}}, 31'd0};

    state_t          r_state;
    state_t          w_state_next;

    // Latched operation context
    logic            r_is_div;
    logic            r_is_rem;
    logic            r_word;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [5:0]      r_cnt;
    // r_acc: product accumulator (MUL) or partial remainder (DIV/REM).
    // r_opa: shifted multiplicand (MUL) or dividend/quotient shifter (DIV/REM).
    // r_opb: multiplier shifted right (MUL) or divisor magnitude (DIV/REM).
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_opa;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_result;

    // Request decode and operand preparation
    logic            w_accept;
    logic            w_is_div;
    logic            w_is_rem;
    logic            w_divrem;
    logic            w_sgn;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_raw;
    logic [XLEN-1:0] w_special_res;

    // Iteration datapath
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;
    logic [5:0]      w_last;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_fix_raw;
    logic [XLEN-1:0] w_fix_res;

    assign ready_o  = (r_state == S_IDLE);
    assign busy_o   = !ready_o;
    assign done_o   = (r_state == S_DONE) && !flush_i;
    assign result_o = r_result;

    assign w_accept = valid_i && ready_o && !flush_i;
    assign w_is_div = (op_i == 2'b01);
    assign w_is_rem = (op_i == 2'b10);
    assign w_divrem = w_is_div || w_is_rem;
    // Only signed divides treat operands as signed. MUL always works on unsigned bits.
    assign w_sgn    = w_divrem && !unsign_i;

    // Operand extension, magnitudes and special-case detection at the active width
    always_comb begin
        w_a_ext       = word_i ? {{32{w_sgn & a_i[31]}}, a_i[31:0]} : a_i;
        w_b_ext       = word_i ? {{32{w_sgn & b_i[31]}}, b_i[31:0]} : b_i;
        w_a_neg       = w_sgn && w_a_ext[XLEN-1];
        w_b_neg       = w_sgn && w_b_ext[XLEN-1];
        w_a_mag       = w_a_neg ? (~w_a_ext + 1'b1) : w_a_ext;
        w_b_mag       = w_b_neg ? (~w_b_ext + 1'b1) : w_b_ext;
        w_div_zero    = (w_b_ext == '0);
        w_ovf         = w_sgn && (w_b_ext == '1) && (w_a_ext == (word_i ? MIN32 : MIN64));
        w_special     = w_divrem && (w_div_zero || w_ovf);
        if (w_div_zero) begin
            w_special_raw = w_is_div ? '1 : w_a_ext;
        end else begin
            w_special_raw = w_is_div ? w_a_ext : '0;
        end
        w_special_res = word_i ? {{32{w_special_raw[31]}}, w_special_raw[31:0]} : w_special_raw;
    end

    // One restoring-divide step and the sign fix-up of the final result
    always_comb begin
        w_rem_sh  = {r_acc, r_opa[XLEN-1]};
        w_diff    = w_rem_sh - {1'b0, r_opb};
        w_qbit    = !w_diff[XLEN];
        w_last    = r_word ? 6'd31 : 6'd63;
        w_quot    = r_neg_q ? (~r_opa + 1'b1) : r_opa;
        w_rem     = r_neg_r ? (~r_acc + 1'b1) : r_acc;
        if (r_is_div) begin
            w_fix_raw = w_quot;
        end else if (r_is_rem) begin
            w_fix_raw = w_rem;
        end else begin
            w_fix_raw = r_acc;
        end
        w_fix_res = r_word ? {{32{w_fix_raw[31]}}, w_fix_raw[31:0]} : w_fix_raw;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush aborts from any state
    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (valid_i) w_state_next = w_special ? S_DONE : S_CALC;
                S_CALC: if (r_cnt == w_last) w_state_next = S_FIX;
                S_FIX:  w_state_next = S_DONE;
                S_DONE: w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Operand latch at accept and one iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_is_rem <= 1'b0;
            r_word   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
        end else if (w_accept) begin
            r_is_div <= w_is_div;
            r_is_rem <= w_is_rem;
            r_word   <= word_i;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_cnt    <= '0;
            r_acc    <= '0;
            if (w_divrem) begin
                // Word dividends sit in the upper half so the MSB-first loop
                // always pulls from bit 63; the quotient fills the low 32 bits.
                r_opa <= word_i ? {w_a_mag[31:0], 32'd0} : w_a_mag;
                r_opb <= w_b_mag;
            end else begin
                r_opa <= w_a_ext;
                r_opb <= w_b_ext;
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_is_div || r_is_rem) begin
                r_acc <= w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                r_opa <= {r_opa[XLEN-2:0], w_qbit};
            end else begin
                r_acc <= r_acc + (r_opb[0] ? r_opa : '0);
                r_opa <= {r_opa[XLEN-2:0], 1'b0};
                r_opb <= {1'b0, r_opb[XLEN-1:1]};
            end
        end
    end

    // Result register: loaded by a special case at accept or on leaving FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
        end else if (w_accept && w_special) begin
            r_result <= w_special_res;
        end else if ((r_state == S_FIX) && !flush_i) begin
            r_result <= w_fix_res;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: table-driven bench for mdu_iter with a result scoreboard,
// plus hand-written flush, reset and held-valid sequences.
module tb_mdu_iter;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic [1:0]  op_i;
    logic        unsign_i;
    logic        word_i;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic        flush_i;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [63:0] result_o;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        uns;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];
    int   nvec;

    mdu_iter dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .op_i     (op_i),
        .unsign_i (unsign_i),
        .word_i   (word_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge of an idle cycle; returns at the negedge of the first ready cycle.
    task automatic run_op(input vec_t v);
        int          lat;
        int          bad;
        logic        seen;
        logic [63:0] exp;
        chk({v.name, "_ready_pre"}, 64'(ready_o), 64'd1);
        op_i     = v.op;
        unsign_i = v.uns;
        word_i   = v.word;
        a_i      = v.a;
        b_i      = v.b;
        valid_i  = 1'b1;
        sb_q.push_back(v.exp);
        @(negedge clk);
        valid_i = 1'b0;
        lat  = 1;
        bad  = 0;
        seen = 1'b0;
        while (lat <= 200) begin
            if (ready_o || !busy_o) bad++;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done_o within 200 cycles, expected at %0d", v.name, v.lat);
            void'(sb_q.pop_front());
        end else begin
            exp = sb_q.pop_front();
            $display("txn %s: a=%h b=%h result=%h expected=%h latency=%0d", v.name, v.a, v.b, result_o, exp, lat);
            chk({v.name, "_result"}, result_o, exp);
            chk({v.name, "_latency"}, 64'(lat), 64'(v.lat));
            chk({v.name, "_busy_window"}, 64'(bad), 64'd0);
            @(negedge clk);
            chk({v.name, "_done_single"}, 64'(done_o), 64'd0);
            chk({v.name, "_ready_post"}, 64'(ready_o), 64'd1);
        end
    endtask

    // Starts a 64-bit DIV, aborts it at t+10 with flush or reset, then runs MUL 3*4.
    task automatic abort_seq(input logic use_reset, input logic [63:0] exp_after);
        int   dones;
        vec_t m;
        op_i = 2'b01; unsign_i = 1'b0; word_i = 1'b0;
        a_i = 64'd1000; b_i = 64'd7;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        dones = 0;
        for (int c = 1; c < 10; c++) begin
            if (done_o) dones++;
            @(negedge clk);
        end
        if (done_o) dones++;
        if (use_reset) reset = 1'b1; else flush_i = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        flush_i = 1'b0;
        if (done_o) dones++;
        $display("txn abort(reset=%0d): ready=%0d result=%h dones=%0d", use_reset, ready_o, result_o, dones);
        chk(use_reset ? "reset_abort_no_done" : "flush_no_done", 64'(dones), 64'd0);
        chk(use_reset ? "reset_abort_ready" : "flush_ready", 64'(ready_o), 64'd1);
        chk(use_reset ? "reset_abort_result" : "flush_result_kept", result_o, exp_after);
        m = '{"MUL_after_abort", 2'b00, 1'b0, 1'b0, 64'd3, 64'd4, 64'd12, 66};
        run_op(m);
    endtask

    initial begin
        int   lat;
        int   dones;
        logic seen;
        logic [63:0] prev;

        reset = 1'b1; valid_i = 1'b0; op_i = 2'b00; unsign_i = 1'b0; word_i = 1'b0;
        a_i = '0; b_i = '0; flush_i = 1'b0;

        vecs[0]  = '{"MUL_7_m3",     2'b00, 1'b0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
        vecs[1]  = '{"DIV_m20_3",    2'b01, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66};
        vecs[2]  = '{"REM_m20_3",    2'b10, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        vecs[3]  = '{"REMU_20_3",    2'b10, 1'b1, 1'b0, 64'd20, 64'd3, 64'd2, 66};
        vecs[4]  = '{"DIVU_5_0",     2'b01, 1'b1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[5]  = '{"REM_5_0",      2'b10, 1'b0, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        vecs[6]  = '{"DIV_ovf",      2'b01, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vecs[7]  = '{"REM_ovf",      2'b10, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        vecs[8]  = '{"MULW_1e4",     2'b00, 1'b0, 1'b1, 64'h1_0000, 64'h1_0000, 64'd0, 34};
        vecs[9]  = '{"DIVUW",        2'b01, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 34};
        vecs[10] = '{"REMW_m7_2",    2'b10, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
        vecs[11] = '{"DIVW_ovf",     2'b01, 1'b0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[12] = '{"DIVU_big",     2'b01, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 66};
        vecs[13] = '{"MUL_op11",     2'b11, 1'b1, 1'b0, 64'h1_0000_0001, 64'd6, 64'h6_0000_0006, 66};
        vecs[14] = '{"MULW_sext",    2'b00, 1'b0, 1'b1, 64'h0000_0000_4000_0000, 64'd3, 64'hFFFF_FFFF_C000_0000, 34};
        vecs[15] = '{"REMUW_100_7",  2'b10, 1'b1, 1'b1, 64'hDEAD_0000_0000_0064, 64'hBEEF_0000_0000_0007, 64'd2, 34};
        nvec = 16;

        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready_o), 64'd1);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < nvec; i++) begin
            run_op(vecs[i]);
        end

        // Flush then reset in the middle of a 64-bit divide
        prev = result_o;
        abort_seq(1'b0, prev);
        abort_seq(1'b1, 64'd0);

        // Held valid with changing operands while busy: only the first MULW 5*6 completes
        op_i = 2'b00; unsign_i = 1'b0; word_i = 1'b1;
        a_i = 64'd5; b_i = 64'd6;
        valid_i = 1'b1;
        sb_q.push_back(64'd30);
        @(negedge clk);
        lat = 1;
        seen = 1'b0;
        while (lat <= 200) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            a_i = {$urandom, $urandom};
            b_i = {$urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        valid_i = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL hold_timeout: no done_o within 200 cycles, expected at 34");
            void'(sb_q.pop_front());
        end else begin
            prev = sb_q.pop_front();
            $display("txn hold_valid MULW 5*6: result=%h expected=%h latency=%0d", result_o, prev, lat);
            chk("hold_result", result_o, prev);
            chk("hold_latency", 64'(lat), 64'd34);
        end
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        chk("hold_single_done", 64'(dones), 64'd0);
        chk("hold_ready_after", 64'(ready_o), 64'd1);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the execute stage. It consumes instructions the decoder flags with `mul_div`, covering MUL/DIV/DIVU/REM/REMU and their W forms. The op class comes from the decoder's ALU function, signedness from `unsign`, and word width from `immextend`. The unit accepts operands after forwarding, runs a radix-2 shift-add or restoring-divide loop, and returns one 64-bit result with a single-cycle done pulse; the pipeline stalls on `busy_o`.

## Interface
- XLEN, 64, operand/result width; fixed at 64, not intended for override.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; wins over every other input.
- valid_i  in  1  request present; accepted when `valid_i & ready_o & !flush_i`.
- op_i  in  2  2'b00 MUL, 2'b01 DIV, 2'b10 REM; 2'b11 treated as MUL.
- unsign_i  in  1  1 = unsigned divide/remainder; ignored for MUL.
- word_i  in  1  1 = W-form: use a_i[31:0], b_i[31:0], sign-extend the 32-bit result.
- a_i  in  64  dividend / multiplicand (rs1).
- b_i  in  64  divisor / multiplier (rs2).
- flush_i  in  1  abort the in-flight op; no done pulse is produced.
- ready_o  out  1  high only in IDLE.
- busy_o  out  1  equals `!ready_o`.
- done_o  out  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  out  64  result; held from the done cycle until the next accept.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- Transitions:
  - IDLE to CALC on accept.
  - IDLE to DONE on accept of a special-case divide (see below).
  - CALC to FIX after N iterations: N = 32 if word_i, else 64.
  - FIX to DONE.
  - DONE to IDLE.
- Operands, op, unsign and word are latched at accept. Inputs are ignored while busy.
- Word operands:
  - Signed ops sign-extend bit 31.
  - Unsigned divides zero-extend.
  - MULW uses low 32 bits unsigned; only the low 32 bits of the product matter.
- MUL: unsigned shift-add over N cycles, one multiplier bit per cycle, LSB first. Keep the low 64 bits of the product, or the low 32 bits for word ops. This yields the correct two's-complement low half for signed operands.
- DIV/REM (signed): take operand magnitudes at accept. Run a restoring divide producing one quotient bit per cycle, MSB first. In FIX:
  - Negate the quotient if the operand signs differ.
  - Give the remainder the dividend's sign.
- DIVU/REMU: no magnitude conversion; FIX passes the value through.
- Special cases are decided at accept. They skip CALC/FIX, load result_o directly, and go to DONE.
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (most-negative ÷ −1, at the active width): DIV returns the dividend; REM returns 0.
- Word results: `{{32{r[31]}}, r[31:0]}` for every W op, including unsigned divides.
- Flush: any state goes to IDLE next cycle with no done_o. result_o keeps its previous value. A valid_i in the same cycle as flush_i is not accepted.

## Timing
- Reset values: state IDLE, ready_o=1, busy_o=0, done_o=0, result_o=0, all iteration counters 0.
- Accept at cycle t: busy_o=1 from t+1.
- Normal completion: done_o at t+N+2, so t+66 for 64-bit ops and t+34 for word ops. ready_o=1 at t+N+3.
- Special case: done_o at t+1, ready_o=1 at t+2.
- A new accept can occur in the first ready cycle after DONE; there is no back-to-back accept in the done cycle.
- done_o never asserts in two consecutive cycles.
- Reset mid-operation behaves like flush, and also clears result_o.

## Test plan
- MUL a=7, b=−3 (0xFFFF_FFFF_FFFF_FFFD), 64-bit → result_o=0xFFFF_FFFF_FFFF_FFEB with done_o at t+66; ready_o low for t+1..t+66.
- DIV a=−20, b=3 signed → 0xFFFF_FFFF_FFFF_FFFA (−6). REM with the same operands → 0xFFFF_FFFF_FFFF_FFFE (−2). REMU a=20, b=3 → 2.
- DIVU a=5, b=0 → 0xFFFF_FFFF_FFFF_FFFF at t+1. REM a=5, b=0 → 5. DIV a=0x8000_0000_0000_0000, b=−1 → 0x8000_0000_0000_0000. REM with the same operands → 0.
- Word ops, each with done_o at t+34:
  - MULW a=0x1_0000, b=0x1_0000 → 0.
  - DIVUW a=0xFFFF_FFFF_8000_0000, b=2 → 0x0000_0000_4000_0000.
  - REMW a=−7, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
  - DIVW a=0x8000_0000, b=−1 (word overflow) → 0xFFFF_FFFF_8000_0000 at t+1.
- Flush at t+10 of a 64-bit DIV → no done_o ever, ready_o=1 at t+11, result_o unchanged. A new MUL a=3, b=4 accepted at t+11 → 12 at t+77. Repeat with reset instead of flush → result_o=0.
- Hold valid_i high during busy with changing a_i/b_i → only the first request completes, and its result uses the operands latched at accept.
